// File: rtl/regwin_spill_ctrl.sv
// Window pointer manager and spill/fill engine for the 8x16 windowed register file.
// Spills the oldest resident window to a memory stack on deep calls and refills it on returns.
module regwin_spill_ctrl #(
    parameter int unsigned        MAX_DEPTH  = 15,
    parameter int unsigned        ADDR_W     = 8,
    parameter logic [ADDR_W-1:0]  SPILL_BASE = 8'hC0,
    parameter int unsigned        DEPTH_W    = $clog2(MAX_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                call,
    input  logic                ret,
    output logic                stall,
    output logic [1:0]          window,
    output logic                rf_own,
    output logic [1:0]          rf_idx,
    input  logic [15:0]         rf_rdata,
    output logic [15:0]         rf_wdata,
    output logic                rf_we,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [15:0]         mem_wdata,
    input  logic [15:0]         mem_rdata,
    input  logic                mem_ack,
    output logic [DEPTH_W-1:0]  depth,
    output logic                err
);

    localparam int unsigned SP_W = $clog2(2 * MAX_DEPTH + 1);
    localparam logic [DEPTH_W-1:0] DEPTH_LIMIT = DEPTH_W'(MAX_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPILL = 2'd1,
        FILL  = 2'd2
    } state_t;

    state_t              state;
    state_t              stateNext;
    logic [1:0]          cwp;
    logic [1:0]          cwpNext;
    logic [1:0]          old;
    logic [1:0]          oldNext;
    logic [1:0]          res;
    logic [1:0]          resNext;
    logic [SP_W-1:0]     sp;
    logic [SP_W-1:0]     spNext;
    logic                k;
    logic                kNext;
    logic [DEPTH_W-1:0]  depthNext;
    logic                errNext;

    // State and bookkeeping registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cwp   <= 2'd0;
            old   <= 2'd0;
            res   <= 2'd1;
            sp    <= '0;
            k     <= 1'b0;
            depth <= '0;
            err   <= 1'b0;
        end else begin
            state <= stateNext;
            cwp   <= cwpNext;
            old   <= oldNext;
            res   <= resNext;
            sp    <= spNext;
            k     <= kNext;
            depth <= depthNext;
            err   <= errNext;
        end
    end

    // Request decode, sequencing and datapath steering
    always_comb begin
        stateNext = state;
        cwpNext   = cwp;
        oldNext   = old;
        resNext   = res;
        spNext    = sp;
        kNext     = k;
        depthNext = depth;
        errNext   = 1'b0;

        stall     = (state != IDLE);
        window    = cwp;
        rf_own    = 1'b0;
        rf_idx    = 2'd0;
        rf_wdata  = 16'd0;
        rf_we     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 16'd0;

        case (state)
            IDLE: begin
                if (call && ret) begin
                    errNext = 1'b1;
                end else if (call && (depth == DEPTH_LIMIT)) begin
                    errNext = 1'b1;
                end else if (ret && (depth == '0)) begin
                    errNext = 1'b1;
                end else if (call) begin
                    if (res != 2'd3) begin
                        cwpNext   = cwp + 2'd1;
                        resNext   = res + 2'd1;
                        depthNext = depth + DEPTH_W'(1);
                    end else begin
                        stateNext = SPILL;
                        kNext     = 1'b0;
                    end
                end else if (ret) begin
                    if (res != 2'd1) begin
                        cwpNext   = cwp - 2'd1;
                        resNext   = res - 2'd1;
                        depthNext = depth - DEPTH_W'(1);
                    end else begin
                        stateNext = FILL;
                        kNext     = 1'b1;
                    end
                end
            end

            SPILL: begin
                rf_own    = 1'b1;
                window    = old;
                rf_idx    = {1'b0, k};
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = SPILL_BASE + ADDR_W'(sp);
                mem_wdata = rf_rdata;
                if (mem_ack) begin
                    spNext = sp + SP_W'(1);
                    if (!k) begin
                        kNext = 1'b1;
                    end else begin
                        cwpNext   = cwp + 2'd1;
                        oldNext   = old + 2'd1;
                        depthNext = depth + DEPTH_W'(1);
                        stateNext = IDLE;
                    end
                end
            end

            FILL: begin
                // The caller's window sits just below cwp; refill top entry first
                rf_own   = 1'b1;
                window   = cwp - 2'd1;
                rf_idx   = {1'b0, k};
                mem_req  = 1'b1;
                mem_we   = 1'b0;
                mem_addr = SPILL_BASE + ADDR_W'(sp) - ADDR_W'(1);
                rf_wdata = mem_rdata;
                rf_we    = mem_ack;
                if (mem_ack) begin
                    spNext = sp - SP_W'(1);
                    if (k) begin
                        kNext = 1'b0;
                    end else begin
                        cwpNext   = cwp - 2'd1;
                        oldNext   = old - 2'd1;
                        depthNext = depth - DEPTH_W'(1);
                        stateNext = IDLE;
                    end
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_regwin_spill_ctrl.sv
// Directed bench for regwin_spill_ctrl with a register-file model and a delay-programmable memory.
module tb_regwin_spill_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic        stall;
    logic [1:0]  window;
    logic        rf_own;
    logic [1:0]  rf_idx;
    logic [15:0] rf_rdata;
    logic [15:0] rf_wdata;
    logic        rf_we;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [3:0]  depth;
    logic        err;

    int nCmp = 0;
    int nBad = 0;

    logic [15:0] rfArr [8];
    logic [15:0] memArr [256];
    logic [2:0]  rfPhys;
    logic        pokeEn = 1'b0;
    logic [2:0]  pokeIdx = 3'd0;
    logic [15:0] pokeVal = 16'd0;
    int          waitCnt;
    int          ackDelay = 0;

    always #5 clk = ~clk;

    regwin_spill_ctrl dut (
        .clk(clk), .rst(rst), .call(call), .ret(ret), .stall(stall), .window(window),
        .rf_own(rf_own), .rf_idx(rf_idx), .rf_rdata(rf_rdata), .rf_wdata(rf_wdata),
        .rf_we(rf_we), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .depth(depth), .err(err)
    );

    // Register file: window w, index i maps to physical (2w + i) mod 8
    assign rfPhys   = {window, 1'b0} + {1'b0, rf_idx};
    assign rf_rdata = rfArr[rfPhys];

    always @(posedge clk) begin
        if (pokeEn) rfArr[pokeIdx] <= pokeVal;
        else if (rf_own && rf_we) rfArr[rfPhys] <= rf_wdata;
    end

    // Memory acks after ackDelay wait cycles
    assign mem_ack   = mem_req && (waitCnt == ackDelay);
    assign mem_rdata = memArr[mem_addr];

    always @(posedge clk) begin
        if (rst) waitCnt <= 0;
        else if (mem_req && !mem_ack) waitCnt <= waitCnt + 1;
        else waitCnt <= 0;
        if (mem_req && mem_ack && mem_we) memArr[mem_addr] <= mem_wdata;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [2:0] idx, input logic [15:0] val);
        pokeEn = 1'b1; pokeIdx = idx; pokeVal = val;
        step;
        pokeEn = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (stall === 1'b1 && n < 40) begin
            step;
            n++;
        end
        nCmp++; if (stall !== 1'b0) begin nBad++; $display("FAIL %s_idle_timeout: stall=%b after %0d cycles", tag, stall, n); end
    endtask

    task automatic test_reset;
        rst = 1'b1; call = 1'b0; ret = 1'b0;
        step; step;
        nCmp++; if (stall !== 1'b0) begin nBad++; $display("FAIL reset_stall: got %b want 0", stall); end
        nCmp++; if (window !== 2'd0) begin nBad++; $display("FAIL reset_window: got %0d want 0", window); end
        nCmp++; if (depth !== 4'd0) begin nBad++; $display("FAIL reset_depth: got %0d want 0", depth); end
        nCmp++; if (mem_req !== 1'b0) begin nBad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        nCmp++; if (rf_own !== 1'b0 || rf_we !== 1'b0 || err !== 1'b0) begin nBad++; $display("FAIL reset_ctrl: own=%b we=%b err=%b want 0", rf_own, rf_we, err); end
        rst = 1'b0;
        step;
    endtask

    task automatic test_calls_resident;
        poke(3'd0, 16'h1111);
        poke(3'd1, 16'h2222);
        for (int i = 1; i <= 2; i++) begin
            call = 1'b1; step; call = 1'b0;
            nCmp++; if (window !== 2'(i)) begin nBad++; $display("FAIL call%0d_window: got %0d want %0d", i, window, i); end
            nCmp++; if (stall !== 1'b0 || mem_req !== 1'b0) begin nBad++; $display("FAIL call%0d_nostall: stall=%b req=%b want 0/0", i, stall, mem_req); end
        end
        nCmp++; if (depth !== 4'd2) begin nBad++; $display("FAIL calls_depth: got %0d want 2", depth); end
    endtask

    task automatic test_spill;
        ackDelay = 0;
        call = 1'b1; step; call = 1'b0;
        nCmp++; if (stall !== 1'b1 || rf_own !== 1'b1 || mem_we !== 1'b1) begin nBad++; $display("FAIL spill0_ctrl: stall=%b own=%b we=%b want 1/1/1", stall, rf_own, mem_we); end
        nCmp++; if (window !== 2'd0 || rf_idx !== 2'd0) begin nBad++; $display("FAIL spill0_sel: win=%0d idx=%0d want 0/0", window, rf_idx); end
        nCmp++; if (mem_addr !== 8'hC0 || mem_wdata !== 16'h1111) begin nBad++; $display("FAIL spill0_bus: addr=%h data=%h want c0/1111", mem_addr, mem_wdata); end
        step;
        nCmp++; if (stall !== 1'b1 || rf_idx !== 2'd1) begin nBad++; $display("FAIL spill1_ctrl: stall=%b idx=%0d want 1/1", stall, rf_idx); end
        nCmp++; if (mem_addr !== 8'hC1 || mem_wdata !== 16'h2222) begin nBad++; $display("FAIL spill1_bus: addr=%h data=%h want c1/2222", mem_addr, mem_wdata); end
        step;
        nCmp++; if (stall !== 1'b0 || window !== 2'd3 || depth !== 4'd3) begin nBad++; $display("FAIL spill_done: stall=%b win=%0d depth=%0d want 0/3/3", stall, window, depth); end
        nCmp++; if (memArr[8'hC0] !== 16'h1111 || memArr[8'hC1] !== 16'h2222) begin nBad++; $display("FAIL spill_mem: c0=%h c1=%h want 1111/2222", memArr[8'hC0], memArr[8'hC1]); end
    endtask

    task automatic test_fill;
        poke(3'd0, 16'hDEAD);
        poke(3'd1, 16'hBEEF);
        ret = 1'b1; step; ret = 1'b0;
        nCmp++; if (window !== 2'd2 || depth !== 4'd2 || stall !== 1'b0) begin nBad++; $display("FAIL ret1: win=%0d depth=%0d stall=%b want 2/2/0", window, depth, stall); end
        ret = 1'b1; step; ret = 1'b0;
        nCmp++; if (window !== 2'd1 || depth !== 4'd1 || stall !== 1'b0) begin nBad++; $display("FAIL ret2: win=%0d depth=%0d stall=%b want 1/1/0", window, depth, stall); end
        ret = 1'b1; step; ret = 1'b0;
        nCmp++; if (stall !== 1'b1 || window !== 2'd0 || rf_idx !== 2'd1 || mem_we !== 1'b0) begin nBad++; $display("FAIL fill0_ctrl: stall=%b win=%0d idx=%0d we=%b want 1/0/1/0", stall, window, rf_idx, mem_we); end
        nCmp++; if (mem_addr !== 8'hC1 || rf_wdata !== 16'h2222 || rf_we !== 1'b1) begin nBad++; $display("FAIL fill0_bus: addr=%h wdata=%h rf_we=%b want c1/2222/1", mem_addr, rf_wdata, rf_we); end
        step;
        nCmp++; if (mem_addr !== 8'hC0 || rf_idx !== 2'd0 || rf_wdata !== 16'h1111) begin nBad++; $display("FAIL fill1_bus: addr=%h idx=%0d wdata=%h want c0/0/1111", mem_addr, rf_idx, rf_wdata); end
        step;
        nCmp++; if (stall !== 1'b0 || window !== 2'd0 || depth !== 4'd0) begin nBad++; $display("FAIL fill_done: stall=%b win=%0d depth=%0d want 0/0/0", stall, window, depth); end
        nCmp++; if (rfArr[0] !== 16'h1111 || rfArr[1] !== 16'h2222) begin nBad++; $display("FAIL fill_rf: r0=%h r1=%h want 1111/2222", rfArr[0], rfArr[1]); end
    endtask

    task automatic test_errors_empty;
        ret = 1'b1; step; ret = 1'b0;
        nCmp++; if (err !== 1'b1 || depth !== 4'd0 || window !== 2'd0 || stall !== 1'b0) begin nBad++; $display("FAIL err_ret_empty: err=%b depth=%0d win=%0d stall=%b want 1/0/0/0", err, depth, window, stall); end
        step;
        nCmp++; if (err !== 1'b0) begin nBad++; $display("FAIL err_ret_pulse: got %b want 0", err); end
        call = 1'b1; ret = 1'b1; step; call = 1'b0; ret = 1'b0;
        nCmp++; if (err !== 1'b1 || depth !== 4'd0 || window !== 2'd0 || stall !== 1'b0) begin nBad++; $display("FAIL err_both: err=%b depth=%0d win=%0d stall=%b want 1/0/0/0", err, depth, window, stall); end
        step;
        nCmp++; if (err !== 1'b0 || window !== 2'd0) begin nBad++; $display("FAIL err_both_pulse: err=%b win=%0d want 0/0", err, window); end
    endtask

    task automatic test_spill_delayed;
        logic [7:0]  expAddr;
        logic [15:0] expData;
        poke(3'd0, 16'h3333);
        poke(3'd1, 16'h4444);
        call = 1'b1; step; step; call = 1'b0;
        nCmp++; if (window !== 2'd2 || stall !== 1'b0) begin nBad++; $display("FAIL dly_setup: win=%0d stall=%b want 2/0", window, stall); end
        ackDelay = 3;
        call = 1'b1; step; call = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expAddr = (i < 4) ? 8'hC0 : 8'hC1;
            expData = (i < 4) ? 16'h3333 : 16'h4444;
            nCmp++;
            if (stall !== 1'b1 || mem_req !== 1'b1 || mem_addr !== expAddr || mem_wdata !== expData || mem_ack !== ((i % 4) == 3)) begin
                nBad++;
                $display("FAIL dly_cycle%0d: stall=%b req=%b addr=%h data=%h ack=%b want 1/1/%h/%h/%b", i, stall, mem_req, mem_addr, mem_wdata, mem_ack, expAddr, expData, ((i % 4) == 3));
            end
            step;
        end
        nCmp++; if (stall !== 1'b0 || window !== 2'd3 || depth !== 4'd3) begin nBad++; $display("FAIL dly_done: stall=%b win=%0d depth=%0d want 0/3/3", stall, window, depth); end
        ackDelay = 0;
    endtask

    task automatic test_depth_limit;
        logic [7:0] expAddr;
        for (int n = 0; n < 12; n++) begin
            expAddr = 8'hC2 + 8'(2 * n);
            call = 1'b1; step; call = 1'b0;
            nCmp++; if (stall !== 1'b1 || mem_addr !== expAddr) begin nBad++; $display("FAIL deep_spill%0d: stall=%b addr=%h want 1/%h", n, stall, mem_addr, expAddr); end
            waitIdle("deep");
        end
        nCmp++; if (depth !== 4'd15) begin nBad++; $display("FAIL deep_depth: got %0d want 15", depth); end
        call = 1'b1; step; call = 1'b0;
        nCmp++; if (err !== 1'b1 || depth !== 4'd15 || stall !== 1'b0) begin nBad++; $display("FAIL err_max: err=%b depth=%0d stall=%b want 1/15/0", err, depth, stall); end
        step;
        nCmp++; if (err !== 1'b0 || depth !== 4'd15) begin nBad++; $display("FAIL err_max_pulse: err=%b depth=%0d want 0/15", err, depth); end
    endtask

    task automatic test_reset_mid_spill;
        int n;
        rst = 1'b1; step; rst = 1'b0;
        call = 1'b1; step; step; call = 1'b0;
        ackDelay = 5;
        call = 1'b1; step; call = 1'b0;
        n = 0;
        while (mem_addr !== 8'hC1 && n < 20) begin
            step;
            n++;
        end
        nCmp++; if (mem_addr !== 8'hC1 || stall !== 1'b1) begin nBad++; $display("FAIL rstmid_reach_k1: addr=%h stall=%b want c1/1", mem_addr, stall); end
        rst = 1'b1; step; rst = 1'b0;
        nCmp++; if (mem_req !== 1'b0 || stall !== 1'b0 || window !== 2'd0 || depth !== 4'd0) begin nBad++; $display("FAIL rstmid_state: req=%b stall=%b win=%0d depth=%0d want 0/0/0/0", mem_req, stall, window, depth); end
        ackDelay = 0;
        call = 1'b1; step; step; step; call = 1'b0;
        nCmp++; if (stall !== 1'b1 || mem_addr !== 8'hC0) begin nBad++; $display("FAIL rstmid_sp_cleared: stall=%b addr=%h want 1/c0", stall, mem_addr); end
        waitIdle("rstmid");
        nCmp++; if (window !== 2'd3 || depth !== 4'd3) begin nBad++; $display("FAIL rstmid_resume: win=%0d depth=%0d want 3/3", window, depth); end
    endtask

    initial begin
        test_reset;
        test_calls_resident;
        test_spill;
        test_fill;
        test_errors_empty;
        test_spill_delayed;
        test_depth_limit;
        test_reset_mid_spill;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/regwin_spill_ctrl.md
Name: regwin_spill_ctrl

Overview:
- Window manager and spill/fill engine that sits on the initiator side of the 8x16 windowed register file.
- Owns the current window pointer and drives the file's `window` select.
- On a call that would overwrite the oldest resident window, it reads that window's private registers out of the file and writes them to a memory stack.
- On a return into a spilled window, it reads them back from memory and writes them into the file. The CPU is stalled while either sequence runs.

Parameters:
- MAX_DEPTH, 15, maximum call nesting depth. A call beyond it is rejected.
- ADDR_W, 8, memory address width.
- SPILL_BASE, 8'hC0, memory address of spill stack entry 0. SPILL_BASE + 2*MAX_DEPTH - 1 must fit in ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- call  in  1  procedure-call request, sampled in IDLE only.
- ret  in  1  procedure-return request, sampled in IDLE only.
- stall  out  1  high whenever state != IDLE. CPU holds call/ret while stall is high.
- window  out  2  window select to the register file (always driven).
- rf_own  out  1  high while the controller drives the file's readReg1/writeReg/writeData/writeEn through the datapath muxes.
- rf_idx  out  2  register index within `window`, used for both read and write.
- rf_rdata  in  16  readData1 from the file (combinational).
- rf_wdata  out  16  write data to the file.
- rf_we  out  1  file write enable.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data, valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle completion of the current request.
- depth  out  clog2(MAX_DEPTH+1)  current nesting depth.
- err  out  1  one-cycle pulse on a rejected request.

Behaviour:
- Window map: window w addresses physical regs (2w + idx) mod 8. Window w+1 overlaps window w's idx 2,3. At most 3 windows are resident.
- Internal state:
  - cwp (2b), current window.
  - old (2b), oldest resident window.
  - res (2b), number of resident windows, range 1..3.
  - sp, spill entries used, range 0..2*MAX_DEPTH.
  - k (1b), sequence index.
- Reset (sync): IDLE, cwp = old = 0, res = 1, depth = sp = 0, k = 0.
  - All outputs 0; window = 0; mem_req drops at the reset edge even mid-transaction.
  - No register-file clear is performed.
- IDLE, outputs: window = cwp, rf_own = 0, rf_we = 0, mem_req = 0.
- IDLE, request handling (evaluated in this order):
  - call & ret both high: no-op, err = 1.
  - call with depth == MAX_DEPTH: no-op, err = 1.
  - ret with depth == 0: no-op, err = 1.
  - call with res < 3: next edge cwp+1, res+1, depth+1. Zero stall cycles.
  - call with res == 3: go to SPILL, k = 0.
  - ret with res > 1: next edge cwp-1, res-1, depth-1.
  - ret with res == 1 (caller is spilled): go to FILL, k = 1.
- SPILL, outputs: rf_own = 1, window = old, rf_idx = k, mem_req = 1, mem_we = 1, mem_addr = SPILL_BASE + sp, mem_wdata = rf_rdata.
- SPILL, on mem_ack:
  - sp+1.
  - If k == 0: set k = 1 and stay in SPILL.
  - Else: cwp+1, old+1, depth+1 (res stays 3), return to IDLE.
  - Without ack, all outputs hold.
- FILL, outputs: rf_own = 1, window = cwp-1, rf_idx = k, mem_req = 1, mem_we = 0, mem_addr = SPILL_BASE + sp - 1, rf_wdata = mem_rdata, rf_we = mem_ack.
- FILL, on mem_ack:
  - sp-1.
  - If k == 1: set k = 0 and stay in FILL.
  - Else: cwp-1, old-1, depth-1 (res stays 1), return to IDLE.
- All window arithmetic is mod 4; sp/depth never wrap (guarded by the err cases).
- Minimum stall is 2 cycles per spill or fill with same-cycle ack. Each cycle of ack delay adds one stall cycle.
- call/ret are ignored while stall = 1.

Test Plan:
- Reset, then 2 calls -> window 0 -> 1 -> 2, depth = 2, stall never high, no mem_req.
- Third call with res = 3, file window 0 preloaded with regs 0 = 16'h1111, 1 = 16'h2222, ack same cycle -> writes to C0 = 1111 and C1 = 2222, stall for 2 cycles, then window = 3, depth = 3.
- Unwind with returns down to res = 1 while spilled data exists, memory returns C1 = 2222 then C0 = 1111 -> rf_we writes idx 1 then idx 0 in window cwp-1, sp back to 0, cwp decremented.
- Spill with mem_ack delayed 3 cycles per beat -> mem_req/addr/wdata stable while waiting, stall = 8 cycles.
- Simultaneous call+ret, ret at depth 0, and call at depth 15 -> err pulse for 1 cycle each, state unchanged.
- rst asserted mid-SPILL (k = 1) -> next edge IDLE, mem_req = 0, window = 0, depth = 0, sp = 0.
